// File: rtl/uart_frame_parser.sv
// Framed command parser between the uart RX FIFO and the command decoder: SOF, LEN, payload, XOR checksum.
// Define FRAME_TIMEOUT_EN to add an inter-byte timeout that aborts a stalled frame with err_code 11.
module uart_frame_parser #(
    parameter int              DBIT           = 8,
    parameter logic [DBIT-1:0] SOF_BYTE       = DBIT'(8'hA5),
    parameter int              MAX_LEN        = 16,
    parameter int              TIMEOUT_CYCLES = 100000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            rx_empty,
    input  logic [DBIT-1:0] r_data,
    output logic            rd_uart,
    output logic [DBIT-1:0] m_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic            m_last,
    output logic            frame_ok,
    output logic            frame_err,
    output logic [1:0]      err_code,
    output logic            busy
);
    localparam int              CNT_W     = $clog2(MAX_LEN + 1);
    localparam logic [DBIT-1:0] MAX_LEN_B = DBIT'(MAX_LEN);
    localparam logic [1:0]      ERR_LEN   = 2'b01;
    localparam logic [1:0]      ERR_CHK   = 2'b10;
    localparam logic [1:0]      ERR_TMO   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CHK
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [DBIT-1:0]  r_chk;
    logic [DBIT-1:0]  r_m_data;
    logic             r_m_valid;
    logic             r_m_last;
    logic             r_frame_ok;
    logic             r_frame_err;
    logic [1:0]       r_err_code;

    logic             w_can_accept;
    logic             w_pop;
    logic             w_timeout;

    // Only the payload state depends on the output slot; every other state drains the FIFO freely.
    always_comb begin
        w_can_accept = 1'b1;
        if (r_state == S_PAYLOAD) begin
            w_can_accept = !r_m_valid || m_ready;
        end
    end

    assign w_pop   = reset_n && !rx_empty && w_can_accept;
    assign rd_uart = w_pop;

`ifdef FRAME_TIMEOUT_EN
    localparam int             TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] r_timer;

    // Only starved cycles count; backpressure with data waiting in the FIFO holds the timer.
    assign w_timeout = (r_state != S_IDLE) && rx_empty && (r_timer == TMR_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n || r_state == S_IDLE || w_pop || w_timeout) begin
            r_timer <= '0;
        end else if (rx_empty) begin
            r_timer <= r_timer + TMR_W'(1);
        end
    end
`else
    // Timer compiled out: the comparison is constant false and keeps the parameter referenced.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_chk       <= '0;
            r_m_data    <= '0;
            r_m_valid   <= 1'b0;
            r_m_last    <= 1'b0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_code  <= 2'b00;
        end else begin
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_code  <= 2'b00;

            if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
            end

            if (w_timeout) begin
                r_frame_err <= 1'b1;
                r_err_code  <= ERR_TMO;
                r_state     <= S_IDLE;
            end else if (w_pop) begin
                case (r_state)
                    S_IDLE: begin
                        if (r_data == SOF_BYTE) begin
                            r_chk   <= '0;
                            r_state <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        r_chk <= r_data;
                        r_cnt <= CNT_W'(r_data);
                        if (r_data == '0 || r_data > MAX_LEN_B) begin
                            r_frame_err <= 1'b1;
                            r_err_code  <= ERR_LEN;
                            r_state     <= S_IDLE;
                        end else begin
                            r_state <= S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        // Slot is known free here, so this load overrides the handshake clear above.
                        r_m_data  <= r_data;
                        r_m_valid <= 1'b1;
                        r_m_last  <= (r_cnt == CNT_W'(1));
                        r_chk     <= r_chk ^ r_data;
                        r_cnt     <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= S_CHK;
                        end
                    end
                    S_CHK: begin
                        if (r_data == r_chk) begin
                            r_frame_ok <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_err_code  <= ERR_CHK;
                        end
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign m_data    = r_m_data;
    assign m_valid   = r_m_valid;
    assign m_last    = r_m_last;
    assign frame_ok  = r_frame_ok;
    assign frame_err = r_frame_err;
    assign err_code  = r_err_code;
    assign busy      = (r_state != S_IDLE);

endmodule
